control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multi-cycle hardwired control unit directly upstream of the CPU datapath.
- Each clock it drives every datapath strobe: register in/out enables, PC/IR/MAR/MDR/Y/Z/HI/LO controls and ALU select.
- Sequences fetch, decode and execute of a reduced instruction set, reading the instruction word back from the datapath IR.
- Stalls on a ready/valid style memory handshake.

Parameters:
- NUM_REGS, 16, number of general registers; sets the width of reg_in/reg_out.
- OPC_W, 5, opcode field width in IR[31:27].

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous active-high reset.
- ir  in  32  current IR contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
- mem_ready  in  1  memory done; completes the current read or write.
- reg_in  out  NUM_REGS  one-hot register load enables (R0in..R15in).
- reg_out  out  NUM_REGS  one-hot register bus drives (R0out..R15out).
- PCin, PCout, IncPC, IRin, Yin, Zin, MARin, MDRin, MDRout, MDRread, HIin, HIout, LOin, LOout, Zhighout, Zlowout, Cout  out  1 each  datapath strobes.
- mem_write  out  1  memory write request.
- ALUselect  out  4  ALU operation code.
- run  out  1  high unless halted.

Behaviour:
- Outputs are Moore: a function of state and the registered ir only.
- While clear=1, and in the cycle after release, all outputs are 0 except run=1.
- FSM state: RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT.
- clear forces RESET immediately, including mid-instruction or mid-handshake. RESET goes to T0 on the next edge.
- Fetch:
  - T0: PCout, MARin, IncPC.
  - T1: MDRread, MDRin, held until mem_ready=1 is sampled; then T2.
  - T2: MDRout, IRin.
- Decode at T3 uses the latched ir. At most one bit of reg_out and one bus source are active in any cycle.
- R-type ALU ops (ADD 00000, SUB 00001, AND 00010, OR 00011, SHR 00100, SHL 00101):
  - T3: reg_out[Rb], Yin.
  - T4: reg_out[Rc], ALUselect=op, Zin.
  - T5: Zlowout, reg_in[Ra]; then T0.
- ADDI 01100:
  - T3: reg_out[Rb], Yin.
  - T4: Cout, ALUselect=ADD, Zin.
  - T5: Zlowout, reg_in[Ra]; then T0.
- LD 00110:
  - T3/T4: same as ADDI.
  - T5: Zlowout, MARin.
  - T6: MDRread, MDRin, held until mem_ready=1.
  - T7: MDRout, reg_in[Ra]; then T0.
- ST 00111:
  - T3–T5: same as LD.
  - T6: reg_out[Ra], MDRin (MDRread=0).
  - T7: mem_write, held until mem_ready=1; then T0.
- MUL 01110 / DIV 01111:
  - T3: reg_out[Ra], Yin.
  - T4: reg_out[Rb], ALUselect=op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin; then T0.
- MFHI 11000 / MFLO 11001:
  - T3: HIout or LOout, reg_in[Ra]; then T0.
- NOP 11010, and any undefined opcode: T3 asserts nothing; then T0.
- HALT 11011: enter HALT with run=0 and all strobes 0; stays there until clear.
- A mem_ready pulse outside T1/T6(LD)/T7(ST) is ignored.
- A mem_ready already high on entry completes the handshake in 1 cycle.
- Instruction latency: ALU 6 cycles with zero memory wait; LD/ST 8 cycles.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams;
  - ALU_ADD..ALU_DIV codes (ADD 0000, SUB 0001, AND 0010, OR 0011, SHR 0100, SHL 0101, MUL 0110, DIV 0111);
  - the state enum;
  - field bit positions.
- One sub-module, reg_select_decoder: 4-bit field to one-hot NUM_REGS, enable-gated. It is instantiated separately for reg_in and reg_out.

Test Plan:
- Reset/fetch: clear pulse, then mem_ready=1.
  - Cycle 1: T0 with PCout=MARin=IncPC=1.
  - Cycle 2: MDRread=MDRin=1.
  - Cycle 3: IRin=1.
- ADD: ir=0x00918000 (ADD R1,R2,R3).
  - T3: reg_out=0x0004, Yin.
  - T4: reg_out=0x0008, ALUselect=0000, Zin.
  - T5: Zlowout, reg_in=0x0002.
- LD with 3-cycle memory wait (ir=0x31100000):
  - T6 holds MDRread for exactly 3 cycles.
  - T7: MDRout with reg_in=0x0004 (Ra=2).
  - Total 10 cycles.
- MUL: ir=0x70918000.
  - T5: Zlowout+LOin.
  - T6: Zhighout+HIin.
  - No reg_in bit set.
- HALT ir=0xD8000000: run drops after T3 and stays 0 for 20 cycles. clear then restores run=1 and T0.
- clear asserted during a T7 store wait: mem_write drops the same cycle (async). After release the sequencer restarts at RESET→T0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired CPU control path: opcodes, ALU codes,
// sequencer states and IR field positions.
package cpu_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHL  = 5'b00101;
  localparam logic [4:0] OP_LD   = 5'b00110;
  localparam logic [4:0] OP_ST   = 5'b00111;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SHR = 4'b0100;
  localparam logic [3:0] ALU_SHL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_DIV = 4'b0111;

  localparam int OPC_MSB = 31;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;
  localparam int FIELD_W = 4;

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT
  } state_t;

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SHR:  return ALU_SHR;
      OP_SHL:  return ALU_SHL;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// Register field to one-hot select; all zeros when disabled or when the
// field names a register that does not exist.
module reg_select_decoder
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                i_en,
  input  logic [FIELD_W-1:0]  i_field,
  output logic [NUM_REGS-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      o_onehot[k] = i_en && (i_field == FIELD_W'(k));
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch/decode/execute sequencing with
// Moore datapath strobes and memory ready stalls.
//
// state | meaning
// RESET | outputs idle, run=1; leaves on the first edge after clear drops
// T0    | PC -> MAR, PC increment
// T1    | memory read into MDR, waits for mem_ready
// T2    | MDR -> IR
// T3-T7 | execute steps, selected by opcode
// HALT  | everything off, run=0, only clear leaves
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int OPC_W    = 5
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                PCin,
  output logic                PCout,
  output logic                IncPC,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                MDRread,
  output logic                HIin,
  output logic                HIout,
  output logic                LOin,
  output logic                LOout,
  output logic                Zhighout,
  output logic                Zlowout,
  output logic                Cout,
  output logic                mem_write,
  output logic [3:0]          ALUselect,
  output logic                run
);

  state_t              r_state;
  state_t              w_next_state;
  logic [OPC_W-1:0]    w_opc;
  logic [FIELD_W-1:0]  w_ra, w_rb, w_rc;
  logic                w_is_alu, w_is_imm, w_is_ld, w_is_st, w_is_md;
  logic                w_in_en, w_out_en;
  logic [FIELD_W-1:0]  w_in_field, w_out_field;
  logic                w_unused_ir;

  assign w_opc       = ir[OPC_MSB -: OPC_W];
  assign w_ra        = ir[RA_LSB +: FIELD_W];
  assign w_rb        = ir[RB_LSB +: FIELD_W];
  assign w_rc        = ir[RC_LSB +: FIELD_W];
  assign w_unused_ir = ^ir[RC_LSB-1:0];

  assign w_is_alu = (w_opc <= OP_SHL);
  assign w_is_imm = (w_opc == OP_ADDI);
  assign w_is_ld  = (w_opc == OP_LD);
  assign w_is_st  = (w_opc == OP_ST);
  assign w_is_md  = (w_opc == OP_MUL) || (w_opc == OP_DIV);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= S_RESET;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    PCin = 1'b0;  PCout = 1'b0;  IncPC = 1'b0;  IRin = 1'b0;
    Yin = 1'b0;   Zin = 1'b0;    MARin = 1'b0;  MDRin = 1'b0;
    MDRout = 1'b0; MDRread = 1'b0; HIin = 1'b0; HIout = 1'b0;
    LOin = 1'b0;  LOout = 1'b0;  Zhighout = 1'b0; Zlowout = 1'b0;
    Cout = 1'b0;  mem_write = 1'b0;
    ALUselect   = ALU_ADD;
    run         = 1'b1;
    w_in_en     = 1'b0;
    w_in_field  = w_ra;
    w_out_en    = 1'b0;
    w_out_field = w_rb;

    case (r_state)
      S_RESET: w_next_state = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        w_next_state = S_T1;
      end
      S_T1: begin
        MDRread = 1'b1; MDRin = 1'b1;
        if (mem_ready) w_next_state = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        w_next_state = S_T3;
      end
      S_T3: begin
        if (w_is_alu || w_is_imm || w_is_ld || w_is_st) begin
          w_out_en = 1'b1; Yin = 1'b1;
          w_next_state = S_T4;
        end else if (w_is_md) begin
          w_out_en = 1'b1; w_out_field = w_ra; Yin = 1'b1;
          w_next_state = S_T4;
        end else if (w_opc == OP_MFHI) begin
          HIout = 1'b1; w_in_en = 1'b1;
          w_next_state = S_T0;
        end else if (w_opc == OP_MFLO) begin
          LOout = 1'b1; w_in_en = 1'b1;
          w_next_state = S_T0;
        end else if (w_opc == OP_HALT) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_T0;
        end
      end
      S_T4: begin
        Zin = 1'b1;
        if (w_is_alu) begin
          w_out_en = 1'b1; w_out_field = w_rc; ALUselect = alu_code(w_opc);
        end else if (w_is_md) begin
          w_out_en = 1'b1; ALUselect = alu_code(w_opc);
        end else begin
          Cout = 1'b1;
        end
        w_next_state = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (w_is_md) begin
          LOin = 1'b1;
          w_next_state = S_T6;
        end else if (w_is_ld || w_is_st) begin
          MARin = 1'b1;
          w_next_state = S_T6;
        end else begin
          w_in_en = 1'b1;
          w_next_state = S_T0;
        end
      end
      S_T6: begin
        if (w_is_md) begin
          Zhighout = 1'b1; HIin = 1'b1;
          w_next_state = S_T0;
        end else if (w_is_st) begin
          w_out_en = 1'b1; w_out_field = w_ra; MDRin = 1'b1;
          w_next_state = S_T7;
        end else begin
          MDRread = 1'b1; MDRin = 1'b1;
          if (mem_ready) w_next_state = S_T7;
        end
      end
      S_T7: begin
        if (w_is_st) begin
          mem_write = 1'b1;
          if (mem_ready) w_next_state = S_T0;
        end else begin
          MDRout = 1'b1; w_in_en = 1'b1;
          w_next_state = S_T0;
        end
      end
      S_HALT: run = 1'b0;
      default: w_next_state = S_RESET;
    endcase
  end

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_in_dec (
    .i_en     (w_in_en),
    .i_field  (w_in_field),
    .o_onehot (reg_in)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_out_dec (
    .i_en     (w_out_en),
    .i_field  (w_out_field),
    .o_onehot (reg_out)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Cycle-script bench for control_sequencer: each instruction is expanded into
// the expected strobe set per cycle and compared against the DUT.
module tb_control_sequencer;

  typedef logic [54:0] vec_t;

  localparam vec_t B_PCOUT   = vec_t'(1) << 1;
  localparam vec_t B_INCPC   = vec_t'(1) << 2;
  localparam vec_t B_IRIN    = vec_t'(1) << 3;
  localparam vec_t B_YIN     = vec_t'(1) << 4;
  localparam vec_t B_ZIN     = vec_t'(1) << 5;
  localparam vec_t B_MARIN   = vec_t'(1) << 6;
  localparam vec_t B_MDRIN   = vec_t'(1) << 7;
  localparam vec_t B_MDROUT  = vec_t'(1) << 8;
  localparam vec_t B_MDRREAD = vec_t'(1) << 9;
  localparam vec_t B_HIIN    = vec_t'(1) << 10;
  localparam vec_t B_HIOUT   = vec_t'(1) << 11;
  localparam vec_t B_LOIN    = vec_t'(1) << 12;
  localparam vec_t B_LOOUT   = vec_t'(1) << 13;
  localparam vec_t B_ZHIGH   = vec_t'(1) << 14;
  localparam vec_t B_ZLOW    = vec_t'(1) << 15;
  localparam vec_t B_COUT    = vec_t'(1) << 16;
  localparam vec_t B_MEMWR   = vec_t'(1) << 17;
  localparam vec_t B_RUN     = vec_t'(1) << 18;

  logic        clock, clear, mem_ready;
  logic [31:0] ir;
  logic [15:0] reg_in, reg_out;
  logic        PCin, PCout, IncPC, IRin, Yin, Zin, MARin, MDRin, MDRout, MDRread;
  logic        HIin, HIout, LOin, LOout, Zhighout, Zlowout, Cout, mem_write, run;
  logic [3:0]  ALUselect;
  vec_t        w_obs;

  control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
    .reg_in(reg_in), .reg_out(reg_out),
    .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .MDRread(MDRread),
    .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .Cout(Cout),
    .mem_write(mem_write), .ALUselect(ALUselect), .run(run)
  );

  assign w_obs = {reg_in, reg_out, ALUselect, run, mem_write, Cout, Zlowout, Zhighout,
                  LOout, LOin, HIout, HIin, MDRread, MDRout, MDRin, MARin, Zin, Yin,
                  IRin, IncPC, PCout, PCin};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        rdy;
    logic [31:0] irv;
    vec_t        exp;
    string       tag;
  } step_t;

  step_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    ops[13] = '{0, 1, 2, 3, 4, 5, 6, 7, 12, 14, 15, 24, 25};

  function automatic vec_t rin(int r);
    return vec_t'(1) << (39 + r);
  endfunction

  function automatic vec_t rout(int r);
    return vec_t'(1) << (23 + r);
  endfunction

  function automatic vec_t alu(int a);
    return vec_t'(a) << 19;
  endfunction

  function automatic logic rbit();
    return ($urandom_range(0, 1) == 1);
  endfunction

  function automatic void push(logic r, logic [31:0] v, vec_t e, string t);
    q.push_back('{rdy: r, irv: v, exp: e, tag: t});
  endfunction

  // w cycles with ready low, then the completing cycle with ready high
  function automatic void push_wait(int w, logic [31:0] v, vec_t e, string t);
    for (int k = 0; k < w; k++) push(1'b0, v, e, t);
    push(1'b1, v, e, t);
  endfunction

  function automatic void model_instr(logic [31:0] instr, int wf, int wm);
    int    op, ra, rb, rc;
    string nm;
    vec_t  fetch_t3;
    op = int'(instr[31:27]);
    ra = int'(instr[26:23]);
    rb = int'(instr[22:19]);
    rc = int'(instr[18:15]);
    nm = $sformatf("op%0d", op);
    push(rbit(), $urandom, B_RUN | B_PCOUT | B_MARIN | B_INCPC, {nm, ".T0"});
    push_wait(wf, $urandom, B_RUN | B_MDRREAD | B_MDRIN, {nm, ".T1"});
    push(rbit(), $urandom, B_RUN | B_MDROUT | B_IRIN, {nm, ".T2"});
    fetch_t3 = B_RUN | rout(rb) | B_YIN;
    if (op <= 5) begin
      push(rbit(), instr, fetch_t3, {nm, ".T3"});
      push(rbit(), instr, B_RUN | rout(rc) | alu(op) | B_ZIN, {nm, ".T4"});
      push(rbit(), instr, B_RUN | B_ZLOW | rin(ra), {nm, ".T5"});
    end else if (op == 12 || op == 6 || op == 7) begin
      push(rbit(), instr, fetch_t3, {nm, ".T3"});
      push(rbit(), instr, B_RUN | B_COUT | alu(0) | B_ZIN, {nm, ".T4"});
      if (op == 12) begin
        push(rbit(), instr, B_RUN | B_ZLOW | rin(ra), {nm, ".T5"});
      end else begin
        push(rbit(), instr, B_RUN | B_ZLOW | B_MARIN, {nm, ".T5"});
        if (op == 6) begin
          push_wait(wm, instr, B_RUN | B_MDRREAD | B_MDRIN, {nm, ".T6"});
          push(rbit(), instr, B_RUN | B_MDROUT | rin(ra), {nm, ".T7"});
        end else begin
          push(rbit(), instr, B_RUN | rout(ra) | B_MDRIN, {nm, ".T6"});
          push_wait(wm, instr, B_RUN | B_MEMWR, {nm, ".T7"});
        end
      end
    end else if (op == 14 || op == 15) begin
      push(rbit(), instr, B_RUN | rout(ra) | B_YIN, {nm, ".T3"});
      push(rbit(), instr, B_RUN | rout(rb) | alu(op == 14 ? 6 : 7) | B_ZIN, {nm, ".T4"});
      push(rbit(), instr, B_RUN | B_ZLOW | B_LOIN, {nm, ".T5"});
      push(rbit(), instr, B_RUN | B_ZHIGH | B_HIIN, {nm, ".T6"});
    end else if (op == 24) begin
      push(rbit(), instr, B_RUN | B_HIOUT | rin(ra), {nm, ".T3"});
    end else if (op == 25) begin
      push(rbit(), instr, B_RUN | B_LOOUT | rin(ra), {nm, ".T3"});
    end else if (op == 27) begin
      push(rbit(), instr, B_RUN, {nm, ".T3"});
      for (int k = 0; k < 20; k++) push(rbit(), instr, vec_t'(0), {nm, ".halted"});
    end else begin
      push(rbit(), instr, B_RUN, {nm, ".T3"});
    end
  endfunction

  task automatic check(string tag, vec_t e);
    n_cmp++;
    assert (w_obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, w_obs, e);
    end
  endtask

  // n < 0 runs the whole script; otherwise stops after n cycles and drops the rest
  task automatic run_steps(int n);
    int    k;
    step_t s;
    k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      s = q.pop_front();
      @(posedge clock);
      #1;
      ir        = s.irv;
      mem_ready = s.rdy;
      @(negedge clock);
      check(s.tag, s.exp);
      k++;
    end
    q.delete();
  endtask

  task automatic do_reset();
    clear = 1'b1;
    #1;
    check("clear_async", B_RUN);
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    @(negedge clock);
    check("reset_release", B_RUN);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] instr;
    int          op;
    clear     = 1'b0;
    mem_ready = 1'b0;
    ir        = 32'h0;
    #2;
    do_reset();

    model_instr(32'h00918000, 0, 0);
    run_steps(-1);
    model_instr(32'h31100000, 0, 2);
    run_steps(-1);
    model_instr(32'h70918000, 1, 0);
    run_steps(-1);
    model_instr(32'h39A00000, 0, 1);
    run_steps(-1);

    for (int i = 0; i < 50; i++) begin
      if ($urandom_range(0, 3) == 0) op = int'($urandom_range(0, 31));
      else                           op = ops[$urandom_range(0, 12)];
      if (op == 27) op = 26;
      instr = {5'(op), 27'($urandom)};
      model_instr(instr, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run_steps(-1);
    end

    model_instr(32'hD8000000, 0, 0);
    run_steps(-1);
    do_reset();
    model_instr(32'h00918000, 0, 0);
    run_steps(-1);

    model_instr(32'h39A00000, 0, 5);
    run_steps(9);
    do_reset();
    model_instr(32'hC9000000, 0, 0);
    run_steps(-1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
